// File: rtl/wrap_mon_pkg.sv
// Shared definitions for the wrap-counter monitor.
//   wm_state_t : monitor FSM state, encoded as reported on the `state` port
//   SAT_STEP   : increment applied by the saturating counters
package wrap_mon_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        TRACK = 2'd2,
        FAULT = 2'd3
    } wm_state_t;

    localparam int SAT_STEP = 1;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear and load.
// Priority: clr, then load, then inc. The counter holds at all-ones.
//   clk, rst_n : clock and asynchronous active-low reset
//   clr        : synchronous clear to zero
//   load       : load load_val
//   inc        : increment by one, saturating
//   count      : current value
module sat_counter
    import wrap_mon_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_reg;
    logic [WIDTH-1:0] count_next;

    always_comb begin
        count_next = count_reg;
        if (clr) begin
            count_next = '0;
        end else if (load) begin
            count_next = load_val;
        end else if (inc && (count_reg != '1)) begin
            count_next = count_reg + WIDTH'(SAT_STEP);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/cycle_wrap_monitor.sv
// Runtime checker and statistics source for a selector-gated wrap counter.
// Samples the counter's c/n outputs plus its advance strobe, flags every wrap,
// counts wraps, measures the clock period between wraps and latches sticky
// faults for c > n and for steps that break the advance rule.
//   clk, rst_n   : clock, asynchronous active-low reset
//   adv          : upstream advance strobe (selector)
//   c_in, n_in   : upstream counter value and limit
//   clr          : synchronous clear of statistics, faults and samples
//   wrap_pulse   : registered one-cycle wrap indication
//   wrap_count   : saturating wrap count
//   last_period  : clocks between the two most recent wraps (saturating)
//   period_valid : last_period holds a real measurement
//   viol         : sticky c_in > n_in
//   step_err     : sticky illegal step
//   state        : FSM state (IDLE/ARMED/TRACK/FAULT)
module cycle_wrap_monitor
    import wrap_mon_pkg::*;
#(
    parameter int W  = 11,
    parameter int CW = 16,
    parameter int PW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          adv,
    input  logic [W-1:0]  c_in,
    input  logic [W-1:0]  n_in,
    input  logic          clr,
    output logic          wrap_pulse,
    output logic [CW-1:0] wrap_count,
    output logic [PW-1:0] last_period,
    output logic          period_valid,
    output logic          viol,
    output logic          step_err,
    output logic [1:0]    state
);

    wm_state_t state_reg;
    wm_state_t state_next;

    // Previous-cycle sample of the upstream counter
    logic          adv_q;
    logic [W-1:0]  c_q;
    logic [W-1:0]  n_q;
    logic          sample_valid_reg;

    logic          wrap_pulse_reg;
    logic [PW-1:0] last_period_reg;
    logic          period_valid_reg;
    logic          viol_reg;
    logic          step_err_reg;

    logic [W-1:0]  c_expect;
    logic          wrap_det;
    logic          step_bad;
    logic          range_bad;
    logic          fault_new;
    logic          counting;

    logic [PW-1:0] period_cnt;
    logic [PW-1:0] period_inc;

    // Value c_in must take given the previous sample
    always_comb begin
        c_expect = c_q;
        if (adv_q) begin
            c_expect = (c_q == n_q) ? W'(1) : c_q + W'(1);
        end
    end

    // adv_q is cleared whenever the sample is invalidated, so a wrap can
    // never be inferred from a stale sample.
    assign wrap_det  = adv_q && (c_q == n_q) && (c_in == W'(1));
    assign step_bad  = sample_valid_reg && (c_in != c_expect);
    assign range_bad = (c_in > n_in);
    assign fault_new = step_bad || range_bad;
    assign counting  = (state_reg == ARMED) || (state_reg == TRACK);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (fault_new) begin
                    state_next = FAULT;
                end else if (adv) begin
                    state_next = ARMED;
                end
            end
            ARMED: begin
                if (fault_new) begin
                    state_next = FAULT;
                end else if (wrap_det) begin
                    state_next = TRACK;
                end
            end
            TRACK: begin
                if (fault_new) begin
                    state_next = FAULT;
                end
            end
            FAULT: begin
                state_next = FAULT;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        if (clr) begin
            state_next = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // First wrap (ARMED) only establishes the time base; later wraps count up.
    sat_counter #(.WIDTH(CW)) u_wrap_count (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (clr),
        .load     ((state_reg == ARMED) && wrap_det),
        .load_val (CW'(1)),
        .inc      ((state_reg == TRACK) && wrap_det),
        .count    (wrap_count)
    );

    // Zeroed on the wrap edge, counts every other edge while tracking.
    sat_counter #(.WIDTH(PW)) u_period_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (clr),
        .load     (counting && wrap_det),
        .load_val ('0),
        .inc      (counting && !wrap_det),
        .count    (period_cnt)
    );

    // The wrap edge itself completes the period, hence the +1.
    assign period_inc = (period_cnt == '1) ? period_cnt : period_cnt + PW'(SAT_STEP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            adv_q            <= 1'b0;
            c_q              <= '0;
            n_q              <= '0;
            sample_valid_reg <= 1'b0;
            wrap_pulse_reg   <= 1'b0;
            last_period_reg  <= '0;
            period_valid_reg <= 1'b0;
            viol_reg         <= 1'b0;
            step_err_reg     <= 1'b0;
        end else if (clr) begin
            adv_q            <= 1'b0;
            c_q              <= '0;
            n_q              <= '0;
            sample_valid_reg <= 1'b0;
            wrap_pulse_reg   <= 1'b0;
            last_period_reg  <= '0;
            period_valid_reg <= 1'b0;
            viol_reg         <= 1'b0;
            step_err_reg     <= 1'b0;
        end else begin
            adv_q            <= adv;
            c_q              <= c_in;
            n_q              <= n_in;
            sample_valid_reg <= 1'b1;
            wrap_pulse_reg   <= wrap_det;
            if ((state_reg == TRACK) && wrap_det) begin
                last_period_reg  <= period_inc;
                period_valid_reg <= 1'b1;
            end
            viol_reg     <= viol_reg | range_bad;
            step_err_reg <= step_err_reg | step_bad;
        end
    end

    assign wrap_pulse   = wrap_pulse_reg;
    assign last_period  = last_period_reg;
    assign period_valid = period_valid_reg;
    assign viol         = viol_reg;
    assign step_err     = step_err_reg;
    assign state        = state_reg;

endmodule

// File: tb/tb_cycle_wrap_monitor.sv
// Self-checking bench for cycle_wrap_monitor. A behavioural model built from
// wrap event times (edge indices) predicts every output after every edge.
module tb_cycle_wrap_monitor;

    localparam int W    = 11;
    localparam int CW   = 4;
    localparam int PW   = 10;
    localparam int CMAX = (1 << CW) - 1;
    localparam int PMAX = (1 << PW) - 1;

    localparam int S_IDLE  = 0;
    localparam int S_ARMED = 1;
    localparam int S_TRACK = 2;
    localparam int S_FAULT = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          adv = 1'b0;
    logic [W-1:0]  c_in = '0;
    logic [W-1:0]  n_in = '0;
    logic          clr = 1'b0;
    logic          wrap_pulse;
    logic [CW-1:0] wrap_count;
    logic [PW-1:0] last_period;
    logic          period_valid;
    logic          viol;
    logic          step_err;
    logic [1:0]    state;

    cycle_wrap_monitor #(.W(W), .CW(CW), .PW(PW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .adv          (adv),
        .c_in         (c_in),
        .n_in         (n_in),
        .clr          (clr),
        .wrap_pulse   (wrap_pulse),
        .wrap_count   (wrap_count),
        .last_period  (last_period),
        .period_valid (period_valid),
        .viol         (viol),
        .step_err     (step_err),
        .state        (state)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference model state
    int m_state, m_wraps, m_lp, m_pv, m_viol, m_step, m_pulse;
    int have_prev, p_adv, p_c, p_n;
    int edge_idx, last_wrap;
    // Upstream counter generator
    int uc, un;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_state = S_IDLE; m_wraps = 0; m_lp = 0; m_pv = 0;
        m_viol = 0; m_step = 0; m_pulse = 0;
        have_prev = 0; p_adv = 0; p_c = 0; p_n = 0;
    endtask

    task automatic check_all();
        check("state", {30'd0, state}, m_state);
        check("wrap_pulse", {31'd0, wrap_pulse}, m_pulse);
        check("wrap_count", {28'd0, wrap_count}, m_wraps);
        check("last_period", {22'd0, last_period}, m_lp);
        check("period_valid", {31'd0, period_valid}, m_pv);
        check("viol", {31'd0, viol}, m_viol);
        check("step_err", {31'd0, step_err}, m_step);
    endtask

    // Apply one cycle of inputs (called just after a rising edge), advance
    // the model across the next edge, then compare.
    task automatic drive_cycle(input logic a, input int ci, input int ni, input logic cl);
        int wrap, bad_step, bad_rng, nxt;
        logic [31:0] cv, nv;
        cv = ci; nv = ni;
        adv = a; c_in = cv[W-1:0]; n_in = nv[W-1:0]; clr = cl;
        wrap = (have_prev != 0) && (p_adv != 0) && (p_c == p_n) && (ci == 1);
        if (p_adv != 0) nxt = (p_c == p_n) ? 1 : (p_c + 1) % (1 << W);
        else            nxt = p_c;
        bad_step = (have_prev != 0) && (ci != nxt);
        bad_rng  = (ci > ni);
        if (cl) begin
            m_reset();
        end else begin
            m_pulse = wrap;
            if (wrap != 0 && m_state == S_ARMED) begin
                m_wraps = 1;
                last_wrap = edge_idx;
            end else if (wrap != 0 && m_state == S_TRACK) begin
                m_wraps = (m_wraps < CMAX) ? m_wraps + 1 : CMAX;
                m_lp = (edge_idx - last_wrap < PMAX) ? edge_idx - last_wrap : PMAX;
                m_pv = 1;
                last_wrap = edge_idx;
            end
            if (bad_rng != 0)  m_viol = 1;
            if (bad_step != 0) m_step = 1;
            if (m_state != S_FAULT && (bad_rng != 0 || bad_step != 0)) m_state = S_FAULT;
            else if (m_state == S_IDLE && a) m_state = S_ARMED;
            else if (m_state == S_ARMED && wrap != 0) m_state = S_TRACK;
            have_prev = 1; p_adv = a; p_c = ci; p_n = ni;
        end
        edge_idx++;
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic counter_cycle(input logic a);
        drive_cycle(a, uc, un, 1'b0);
        if (a) uc = (uc == un) ? 1 : uc + 1;
    endtask

    task automatic clear_cycle();
        drive_cycle(1'b0, 0, un, 1'b1);
    endtask

    // Run the legal counter until the model reports two wraps; checks the
    // spec-fixed values at the first wrap.
    task automatic run_two_wraps(input string tag, input int limit, input bit toggle);
        int seen;
        seen = 0;
        for (int i = 0; i < limit && seen < 2; i++) begin
            counter_cycle(toggle ? ((i % 2) == 0) : 1'b1);
            if (m_pulse != 0) begin
                seen++;
                if (seen == 1) begin
                    check({tag, "_first_pulse"}, {31'd0, wrap_pulse}, 1);
                    check({tag, "_first_count"}, {28'd0, wrap_count}, 1);
                    check({tag, "_first_valid"}, {31'd0, period_valid}, 0);
                end
            end
        end
        check({tag, "_wraps_in_budget"}, seen, 2);
    endtask

    initial begin
        edge_idx = 0; last_wrap = 0; uc = 0; un = 200;
        m_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        check_all();
        rst_n = 1'b1;

        // Constant advance, n = 200
        uc = 0; un = 200;
        run_two_wraps("p1", 1000, 1'b0);
        check("p1_last_period", {22'd0, last_period}, 200);
        check("p1_wrap_count", {28'd0, wrap_count}, 2);
        check("p1_state", {30'd0, state}, S_TRACK);
        $display("phase const_adv: wrap_count=%0d last_period=%0d", wrap_count, last_period);

        // Advance toggling every cycle
        uc = 0; clear_cycle();
        for (int i = 0; i < 1300; i++) counter_cycle((i % 2) == 0);
        check("p2_last_period", {22'd0, last_period}, 400);
        check("p2_step_err", {31'd0, step_err}, 0);
        $display("phase toggle_adv: last_period=%0d step_err=%0d", last_period, step_err);

        // Step-rule violation while tracking, then clear
        uc = 0; un = 10; clear_cycle();
        run_two_wraps("p3", 100, 1'b0);
        for (int i = 0; i < 20 && uc != 3; i++) counter_cycle(1'b1);
        counter_cycle(1'b1);
        drive_cycle(1'b1, 5, 10, 1'b0);
        check("p3_step_err", {31'd0, step_err}, 1);
        check("p3_state", {30'd0, state}, S_FAULT);
        for (int i = 0; i < 30; i++) counter_cycle(1'b1);
        check("p3_frozen_count", {28'd0, wrap_count}, 2);
        check("p3_frozen_period", {22'd0, last_period}, 10);
        clear_cycle();
        check("p3_clr_state", {30'd0, state}, S_IDLE);
        check("p3_clr_step", {31'd0, step_err}, 0);
        check("p3_clr_count", {28'd0, wrap_count}, 0);
        $display("phase step_fault: state=%0d after clr", state);

        // Range violation stays sticky
        un = 200;
        drive_cycle(1'b0, 201, 200, 1'b0);
        check("p4_viol", {31'd0, viol}, 1);
        check("p4_state", {30'd0, state}, S_FAULT);
        for (int i = 0; i < 10; i++) drive_cycle(1'b0, 100, 200, 1'b0);
        check("p4_viol_sticky", {31'd0, viol}, 1);
        $display("phase range_fault: viol=%0d", viol);

        // Period saturation: wrap every 2^PW + 10 edges
        uc = 0; un = PMAX + 11; clear_cycle();
        run_two_wraps("p5", 2500, 1'b0);
        check("p5_sat_period", {22'd0, last_period}, PMAX);
        check("p5_valid", {31'd0, period_valid}, 1);
        $display("phase period_sat: last_period=%0d", last_period);

        // Wrap-count saturation, then asynchronous reset mid-TRACK
        uc = 0; un = 3; clear_cycle();
        for (int i = 0; i < 80; i++) counter_cycle(1'b1);
        check("p6_sat_count", {28'd0, wrap_count}, CMAX);
        #2 rst_n = 1'b0;
        #1;
        check("rst_state", {30'd0, state}, S_IDLE);
        check("rst_count", {28'd0, wrap_count}, 0);
        check("rst_period", {22'd0, last_period}, 0);
        check("rst_valid", {31'd0, period_valid}, 0);
        check("rst_pulse", {31'd0, wrap_pulse}, 0);
        m_reset();
        @(posedge clk);
        #1;
        check_all();
        rst_n = 1'b1;
        uc = (uc + 2) % (un + 1);
        for (int i = 0; i < 10; i++) counter_cycle(1'b1);
        check("p6_no_false_step", {31'd0, step_err}, 0);
        $display("phase async_reset: step_err=%0d state=%0d", step_err, state);

        // Randomised rounds with occasional corrupt samples and clears
        for (int r = 0; r < 20; r++) begin
            un = $urandom_range(2, 20);
            uc = $urandom_range(0, un);
            clear_cycle();
            for (int i = 0; i < 60; i++) begin
                int pick;
                pick = $urandom_range(0, 99);
                if (pick < 3) drive_cycle(1'($urandom_range(0, 1)), $urandom_range(0, 40), un, 1'b0);
                else if (pick < 5) clear_cycle();
                else counter_cycle(1'($urandom_range(0, 3) != 0));
            end
            $display("phase random_%0d: n=%0d state=%0d wraps=%0d", r, un, state, wrap_count);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL timeout got=%0d exp=%0d", 0, 1);
        $fatal(1, "bench time limit reached");
    end

endmodule
